// File: rtl/fx_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fx_arb_pkg : shared widths, state encoding and defaults          |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package fx_arb_pkg;
  localparam int FX_AW      = 22;
  localparam int FX_DW      = 8;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    ACK   = 3'd4
  } state_t;
endpackage
`default_nettype wire

// File: rtl/fx_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fx_rr_pick : combinational 2-way round-robin picker              |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module fx_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;  // tie goes to whoever was not granted last
      default: gnt_idx = 1'b0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/fx_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fx_arb : two-master arbiter onto a single fixed-latency slave    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module fx_arb
  import fx_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_wr,
  input  logic [FX_AW-1:0] m0_addr,
  input  logic [FX_DW-1:0] m0_wdata,
  output logic             m0_ack,
  output logic [FX_DW-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_wr,
  input  logic [FX_AW-1:0] m1_addr,
  input  logic [FX_DW-1:0] m1_wdata,
  output logic             m1_ack,
  output logic [FX_DW-1:0] m1_rdata,
  output logic             fx_wr,
  output logic [FX_AW-1:0] fx_waddr,
  output logic [FX_DW-1:0] fx_data,
  output logic             fx_rd,
  output logic [FX_AW-1:0] fx_raddr,
  input  logic [FX_DW-1:0] fx_q
);
  localparam logic [3:0] LAT4 = 4'(RD_LAT);

  state_t           state;
  logic             last;
  logic [3:0]       cnt;
  logic             gnt_valid;
  logic             gnt_idx;
  logic             win_wr;
  logic [FX_AW-1:0] win_addr;
  logic [FX_DW-1:0] win_wdata;

  fx_rr_pick u_pick (
    .req       ({m1_req, m0_req}),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign win_wr    = gnt_idx ? m1_wr    : m0_wr;
  assign win_addr  = gnt_idx ? m1_addr  : m0_addr;
  assign win_wdata = gnt_idx ? m1_wdata : m0_wdata;

  // 'last' doubles as the index of the transaction in flight.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      cnt      <= 4'd0;
      fx_wr    <= 1'b0;
      fx_rd    <= 1'b0;
      fx_waddr <= '0;
      fx_raddr <= '0;
      fx_data  <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      fx_wr  <= 1'b0;
      fx_rd  <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            last     <= gnt_idx;
            fx_waddr <= win_addr;
            fx_raddr <= win_addr;
            fx_data  <= win_wdata;
            if (win_wr) begin
              fx_wr <= 1'b1;
              state <= WR;
            end else begin
              fx_rd <= 1'b1;
              state <= RD;
            end
          end
        end
        WR: begin
          state <= ACK;
          if (last) m1_ack <= 1'b1;
          else      m0_ack <= 1'b1;
        end
        RD: begin
          cnt   <= LAT4;
          state <= RWAIT;
        end
        RWAIT: begin
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= ACK;
            if (last) begin
              m1_ack   <= 1'b1;
              m1_rdata <= fx_q;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= fx_q;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fx_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fx_arb : scoreboard bench, instances with RD_LAT 2, 1 and 15  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fx_arb;
  localparam int NI = 3;

  typedef struct {
    string       nm;
    int          inst;
    int          kind;   // 0 slave write, 1 slave read, 2 ack
    int          cyc;
    int          idx;
    bit          wr;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [7:0]  r0;
    logic [7:0]  r1;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req [NI];
  logic        m1_req [NI];
  logic        m0_wr, m1_wr;
  logic [21:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic [7:0]  fx_q;
  logic        m0_ack [NI];
  logic        m1_ack [NI];
  logic [7:0]  m0_rdata [NI];
  logic [7:0]  m1_rdata [NI];
  logic        fx_wr [NI];
  logic        fx_rd [NI];
  logic [21:0] fx_waddr [NI];
  logic [21:0] fx_raddr [NI];
  logic [7:0]  fx_data [NI];

  ev_t        exp_q [$];
  logic [7:0] er [NI][2];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    fx_arb #(.RD_LAT(LAT)) u_dut (
      .clk_sys  (clk),
      .rst      (rst),
      .m0_req   (m0_req[k]),
      .m0_wr    (m0_wr),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_ack   (m0_ack[k]),
      .m0_rdata (m0_rdata[k]),
      .m1_req   (m1_req[k]),
      .m1_wr    (m1_wr),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_ack   (m1_ack[k]),
      .m1_rdata (m1_rdata[k]),
      .fx_wr    (fx_wr[k]),
      .fx_waddr (fx_waddr[k]),
      .fx_data  (fx_data[k]),
      .fx_rd    (fx_rd[k]),
      .fx_raddr (fx_raddr[k]),
      .fx_q     (fx_q)
    );
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_model();
    for (int k = 0; k < NI; k++) begin
      er[k][0] = 8'h00;
      er[k][1] = 8'h00;
    end
  endtask

  task automatic exp_wr(input string nm, input int k, input int m, input int c,
                        input logic [21:0] a, input logic [7:0] d);
    ev_t e;
    e = '{nm: nm, inst: k, kind: 0, cyc: c + 1, idx: m, wr: 1'b1, addr: a, data: d,
          r0: 8'h00, r1: 8'h00};
    exp_q.push_back(e);
    e = '{nm: nm, inst: k, kind: 2, cyc: c + 2, idx: m, wr: 1'b1, addr: a, data: d,
          r0: er[k][0], r1: er[k][1]};
    exp_q.push_back(e);
  endtask

  task automatic exp_rd(input string nm, input int k, input int m, input int c,
                        input int lat, input logic [21:0] a, input logic [7:0] q);
    ev_t e;
    e = '{nm: nm, inst: k, kind: 1, cyc: c + 1, idx: m, wr: 1'b0, addr: a, data: 8'h00,
          r0: 8'h00, r1: 8'h00};
    exp_q.push_back(e);
    er[k][m] = q;
    e = '{nm: nm, inst: k, kind: 2, cyc: c + 2 + lat, idx: m, wr: 1'b0, addr: a,
          data: q, r0: er[k][0], r1: er[k][1]};
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input int kind, input int idx,
                          input logic [21:0] wa, input logic [21:0] ra,
                          input logic [7:0] d, input logic [7:0] r0, input logic [7:0] r1);
    ev_t e;
    bit  ok;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event inst%0d cyc%0d kind%0d idx%0d: got an event, required none",
               k, cyc, kind, idx);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.inst == k) && (e.kind == kind) && (e.cyc == cyc);
    case (kind)
      0:       ok = ok && (wa == e.addr) && (d == e.data);
      1:       ok = ok && (ra == e.addr);
      default: ok = ok && (idx == e.idx) && (r0 == e.r0) && (r1 == e.r1) &&
                   ((e.wr ? wa : ra) == e.addr);
    endcase
    if (ok) n_pass++;
    else
      $display("FAIL %s: got inst%0d kind%0d cyc%0d idx%0d wa %h ra %h d %h r0 %h r1 %h; required inst%0d kind%0d cyc%0d idx%0d addr %h d %h r0 %h r1 %h",
               e.nm, k, kind, cyc, idx, wa, ra, d, r0, r1,
               e.inst, e.kind, e.cyc, e.idx, e.addr, e.data, e.r0, e.r1);
  endtask

  // Monitor: every slave strobe and every ack must match the next expected event.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        if (fx_wr[k])  check_ev(k, 0, 0, fx_waddr[k], fx_raddr[k], fx_data[k], 8'h00, 8'h00);
        if (fx_rd[k])  check_ev(k, 1, 0, fx_waddr[k], fx_raddr[k], 8'h00, 8'h00, 8'h00);
        if (m0_ack[k]) check_ev(k, 2, 0, fx_waddr[k], fx_raddr[k], 8'h00, m0_rdata[k], m1_rdata[k]);
        if (m1_ack[k]) check_ev(k, 2, 1, fx_waddr[k], fx_raddr[k], 8'h00, m0_rdata[k], m1_rdata[k]);
      end
    end
  end

  task automatic check_zero(input string nm, input int k);
    bit ok;
    n_chk++;
    ok = !fx_wr[k] && !fx_rd[k] && !m0_ack[k] && !m1_ack[k] && fx_waddr[k] == 22'h0 &&
         fx_raddr[k] == 22'h0 && fx_data[k] == 8'h00 && m0_rdata[k] == 8'h00 &&
         m1_rdata[k] == 8'h00;
    if (ok) n_pass++;
    else
      $display("FAIL %s inst%0d: got wr%b rd%b ack%b%b wa %h ra %h d %h r %h %h, required all zero",
               nm, k, fx_wr[k], fx_rd[k], m0_ack[k], m1_ack[k], fx_waddr[k], fx_raddr[k],
               fx_data[k], m0_rdata[k], m1_rdata[k]);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      m0_req[k] = 1'b0;
      m1_req[k] = 1'b0;
    end
    m0_wr = 1'b0; m1_wr = 1'b0;
    m0_addr = '0; m1_addr = '0;
    m0_wdata = '0; m1_wdata = '0;
    fx_q = 8'h00;
    clr_model();
    tick(2);
    for (int k = 0; k < NI; k++) check_zero("reset_state", k);
    rst = 1'b0;
    tick(2);

    // m0 write alone
    c = cyc;
    m0_wr = 1'b1; m0_addr = 22'h000010; m0_wdata = 8'hA5; m0_req[0] = 1'b1;
    exp_wr("m0_write", 0, 0, c, 22'h000010, 8'hA5);
    tick(3);
    m0_req[0] = 1'b0;
    tick(2);

    // m1 read at top address, slave data valid only in the last wait cycle
    c = cyc;
    fx_q = 8'hEE;
    m1_wr = 1'b0; m1_addr = 22'h3FFFFF; m1_req[0] = 1'b1;
    exp_rd("m1_read_lat2", 0, 1, c, 2, 22'h3FFFFF, 8'h5C);
    tick(3); fx_q = 8'h5C;
    tick(1); fx_q = 8'hEE;
    tick(1); m1_req[0] = 1'b0;
    tick(2);

    // fresh reset, then both masters request continuously
    rst = 1'b1; clr_model(); tick(1); rst = 1'b0; tick(2);
    c = cyc;
    m0_wr = 1'b1; m0_addr = 22'h0000A0; m0_wdata = 8'h11;
    m1_wr = 1'b1; m1_addr = 22'h0000A1; m1_wdata = 8'h22;
    m0_req[0] = 1'b1; m1_req[0] = 1'b1;
    exp_wr("rr_1_m0", 0, 0, c,     22'h0000A0, 8'h11);
    exp_wr("rr_2_m1", 0, 1, c + 3, 22'h0000A1, 8'h22);
    exp_wr("rr_3_m0", 0, 0, c + 6, 22'h0000A0, 8'h11);
    exp_wr("rr_4_m1", 0, 1, c + 9, 22'h0000A1, 8'h22);
    tick(12);
    m0_req[0] = 1'b0; m1_req[0] = 1'b0;
    tick(2);

    // RD_LAT = 1
    c = cyc;
    m0_wr = 1'b0; m0_addr = 22'h123456; m0_req[1] = 1'b1;
    exp_rd("m0_read_lat1", 1, 0, c, 1, 22'h123456, 8'h3C);
    tick(2); fx_q = 8'h3C;
    tick(1); fx_q = 8'hEE;
    tick(1); m0_req[1] = 1'b0;
    tick(2);

    // RD_LAT = 15
    c = cyc;
    m1_wr = 1'b0; m1_addr = 22'h2AAAAA; m1_req[2] = 1'b1;
    exp_rd("m1_read_lat15", 2, 1, c, 15, 22'h2AAAAA, 8'hC3);
    tick(16); fx_q = 8'hC3;
    tick(1);  fx_q = 8'hEE;
    tick(1);  m1_req[2] = 1'b0;
    tick(2);

    // reset during RWAIT aborts the read with no ack
    c = cyc;
    m0_wr = 1'b0; m0_addr = 22'h000777; m0_req[0] = 1'b1;
    begin
      ev_t e;
      e = '{nm: "abort_rd_strobe", inst: 0, kind: 1, cyc: c + 1, idx: 0, wr: 1'b0,
            addr: 22'h000777, data: 8'h00, r0: 8'h00, r1: 8'h00};
      exp_q.push_back(e);
    end
    tick(2);
    rst = 1'b1;
    #1;
    check_zero("reset_mid_rwait", 0);
    m0_req[0] = 1'b0;
    clr_model();
    tick(2);
    rst = 1'b0;
    tick(2);
    c = cyc;
    m0_wr = 1'b1; m0_addr = 22'h000888; m0_wdata = 8'h5A; m0_req[0] = 1'b1;
    exp_wr("write_after_abort", 0, 0, c, 22'h000888, 8'h5A);
    tick(3);
    m0_req[0] = 1'b0;
    tick(2);

    // m0 drops req right after grant; the read still completes once
    c = cyc;
    m0_wr = 1'b0; m0_addr = 22'h1F0F0F; m0_req[0] = 1'b1;
    exp_rd("read_req_drop", 0, 0, c, 2, 22'h1F0F0F, 8'h99);
    tick(1); m0_req[0] = 1'b0;
    tick(2); fx_q = 8'h99;
    tick(1); fx_q = 8'hEE;
    tick(4);

    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL missing_events: got %0d events still pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fx_arb.md
FX_ARB -- requirements
Module: fx_arb

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 2, meaning slave read latency in clk_sys cycles from fx_rd high to fx_q valid (legal range 1..15).
REQ-002 Port clk_sys input 1: the single system clock; all logic SHALL be on its rising edge.
REQ-003 Port rst input 1: reset, asynchronous assert, active-high.
REQ-004 Ports m0_req / m1_req input 1: the requester holds it high until its ack.
REQ-005 Ports m0_wr / m1_wr input 1: 1 = write, 0 = read; valid while req is high.
REQ-006 Ports m0_addr / m1_addr input 22: target address.
REQ-007 Ports m0_wdata / m1_wdata input 8: write data.
REQ-008 Ports m0_ack / m1_ack output 1: one-cycle transaction-complete pulse.
REQ-009 Ports m0_rdata / m1_rdata output 8: read data, valid in the ack cycle.
REQ-010 Slave-side ports SHALL be: fx_wr output 1; fx_waddr output 22; fx_data output 8; fx_rd output 1; fx_raddr output 22; fx_q input 8.

Function
REQ-011 The FSM SHALL have states IDLE, WR, RD, RWAIT and ACK, and all slave-side outputs SHALL be registered.
REQ-012 In IDLE with exactly one req high, that requester SHALL be granted at the clock edge.
REQ-013 In IDLE with both reqs high, the requester not granted most recently SHALL win; after reset m0 wins the first tie.
REQ-014 On grant, the FSM SHALL latch the winner's wr, addr and wdata, then go to WR if wr = 1, else to RD.
REQ-015 WR SHALL last one cycle, with fx_wr = 1, fx_waddr = latched addr and fx_data = latched wdata; the next state is ACK.
REQ-016 RD SHALL last one cycle, with fx_rd = 1 and fx_raddr = latched addr; the next state is RWAIT.
REQ-017 RWAIT SHALL last exactly RD_LAT cycles, counted by a 4-bit down-counter; fx_q SHALL be captured on the last RWAIT cycle; the next state is ACK.
REQ-018 ACK SHALL last one cycle and assert only the granted requester's ack; for a read, that requester's rdata SHALL equal the captured fx_q; the next state is IDLE.
REQ-019 Cycle budget with req first seen in IDLE at cycle 0: a write SHALL have fx_wr high in cycle 1 and ack in cycle 2; a read SHALL have fx_rd high in cycle 1 and ack in cycle 2+RD_LAT.
REQ-020 fx_waddr, fx_raddr and fx_data SHALL hold their value from grant through ACK and afterwards until the next grant.
REQ-021 fx_wr and fx_rd SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per transaction.
REQ-022 If a req drops mid-transaction, the transaction SHALL still complete and ack SHALL still pulse.
REQ-023 A req still high in the ACK cycle SHALL NOT be treated as a new request; re-arbitration SHALL occur only in IDLE (minimum one IDLE cycle between transactions).
REQ-024 The last-grant pointer SHALL update only on grant.
REQ-025 The non-granted requester's ack SHALL stay 0.
REQ-026 Each mN_rdata SHALL hold its last value until that requester's next read ack.

Reset
REQ-027 While rst = 1, the FSM SHALL be in IDLE, and fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, m0_ack, m1_ack, m0_rdata, m1_rdata and the RWAIT counter SHALL be 0; the last-grant pointer SHALL be 1 (m1).
REQ-028 A reset asserted mid-transaction SHALL abort it immediately with no ack; after release the FSM SHALL restart from IDLE.

Structure
REQ-029 A shared package fx_arb_pkg SHALL hold: FX_AW = 22, FX_DW = 8, the state enum, and the RD_LAT default.
REQ-030 One sub-module SHALL be used: fx_rr_pick, a combinational 2-way round-robin picker (inputs: req[1:0], last; outputs: gnt_valid, gnt_idx); all other logic SHALL be in fx_arb.

Verification
REQ-031 m0 write addr 0x000010, data 0xA5 alone -> fx_wr high in cycle 1 only, with fx_waddr 0x000010 and fx_data 0xA5; m0_ack in cycle 2; m1_ack stays 0.
REQ-032 m1 read addr 0x3FFFFF, RD_LAT = 2, slave drives fx_q 0x5C in cycle 3 -> fx_rd high in cycle 1 with fx_raddr 0x3FFFFF; m1_ack in cycle 4 with m1_rdata 0x5C.
REQ-033 m0 and m1 both request continuously after reset -> grants alternate m0, m1, m0, m1; each ack is one cycle; no two acks overlap; there is one IDLE cycle between transactions.
REQ-034 RD_LAT = 1 and RD_LAT = 15 reads -> ack in cycle 3 and cycle 17 respectively; captured data is correct.
REQ-035 rst asserted during RWAIT -> no ack; outputs zero within the same cycle; a subsequent m0 write completes normally.
REQ-036 m0 drops req one cycle after grant during a read -> the read still completes and m0_ack pulses once.
